axi_data_downsizer: RTL and testbench

//  Width downsizer placed directly downstream of full_register_slice. Accepts one wide
//  {id, addr, data} word per valid/ready handshake and emits it as RATIO narrow beats,

---
 rtl/axi_slice_pkg.sv | 27 ++
 rtl/axi_data_downsizer.sv | 90 +++++++++
 tb/tb_axi_data_downsizer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axi_slice_pkg.sv
// rtl/axi_slice_pkg.sv - shared widths and word/beat types for the AXI slice datapath
package axi_slice_pkg;

  localparam int ID_WIDTH       = 3;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int OUT_DATA_WIDTH = 8;

  // Wide word as carried by full_register_slice; field order matches the bus packing.
  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } axi_word_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]       id;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [OUT_DATA_WIDTH-1:0] data;
  } axi_beat_t;

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_SEND = 1'b1
  } ds_state_t;

endpackage

// File: rtl/axi_data_downsizer.sv
// rtl/axi_data_downsizer.sv - splits one wide {id,addr,data} word into RATIO narrow addressed beats
module axi_data_downsizer #(
  parameter int ID_WIDTH       = axi_slice_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH     = axi_slice_pkg::ADDR_WIDTH,
  parameter int IN_DATA_WIDTH  = axi_slice_pkg::DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = axi_slice_pkg::OUT_DATA_WIDTH
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic [ID_WIDTH+ADDR_WIDTH+IN_DATA_WIDTH-1:0]  prev_stage_data_i,
  input  logic                                       prev_stage_valid_i,
  output logic                                       prev_stage_ready_o,
  output logic [ID_WIDTH+ADDR_WIDTH+OUT_DATA_WIDTH-1:0] next_stage_data_o,
  output logic                                       next_stage_last_o,
  output logic                                       next_stage_valid_o,
  input  logic                                       next_stage_ready_i
);
  import axi_slice_pkg::*;

  localparam int RATIO      = IN_DATA_WIDTH / OUT_DATA_WIDTH;
  localparam int CNT_W      = $clog2(RATIO);
  localparam int BEAT_BYTES = OUT_DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  ds_state_t state, state_nxt;

  logic [ID_WIDTH-1:0]       hold_id;
  logic [ADDR_WIDTH-1:0]     hold_addr;
  logic [IN_DATA_WIDTH-1:0]  hold_data;
  logic [CNT_W-1:0]          beat_cnt;

  logic [ID_WIDTH-1:0]       in_id;
  logic [ADDR_WIDTH-1:0]     in_addr;
  logic [IN_DATA_WIDTH-1:0]  in_data;
  logic [ADDR_WIDTH-1:0]     beat_addr;
  logic [OUT_DATA_WIDTH-1:0] beat_data;
  logic                      busy;
  logic                      last_beat;
  logic                      beat_acc;
  logic                      in_acc;

  assign in_id   = prev_stage_data_i[ID_WIDTH+ADDR_WIDTH+IN_DATA_WIDTH-1 -: ID_WIDTH];
  assign in_addr = prev_stage_data_i[ADDR_WIDTH+IN_DATA_WIDTH-1 -: ADDR_WIDTH];
  assign in_data = prev_stage_data_i[IN_DATA_WIDTH-1:0];

  assign busy      = (state == DS_SEND);
  assign last_beat = (beat_cnt == LAST_CNT);
  assign beat_acc  = busy & next_stage_ready_i;

  // Reload on the last beat keeps the output stream bubble-free across words.
  assign prev_stage_ready_o = !areset & (!busy | (last_beat & next_stage_ready_i));
  assign in_acc             = prev_stage_valid_i & prev_stage_ready_o;

  assign beat_addr = hold_addr + ADDR_WIDTH'(beat_cnt) * ADDR_WIDTH'(BEAT_BYTES);
  assign beat_data = hold_data[int'(beat_cnt)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];

  assign next_stage_data_o  = {hold_id, beat_addr, beat_data};
  assign next_stage_valid_o = busy;
  assign next_stage_last_o  = busy & last_beat;

  always_comb begin
    state_nxt = state;
    case (state)
      DS_IDLE: if (in_acc) state_nxt = DS_SEND;
      DS_SEND: if (beat_acc && last_beat && !in_acc) state_nxt = DS_IDLE;
      default: state_nxt = DS_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= DS_IDLE;
      beat_cnt  <= '0;
      hold_id   <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state <= state_nxt;
      if (in_acc) begin
        hold_id   <= in_id;
        hold_addr <= in_addr;
        hold_data <= in_data;
        beat_cnt  <= '0;
      end else if (beat_acc) begin
        beat_cnt  <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_data_downsizer.sv
// tb/tb_axi_data_downsizer.sv - directed self-checking bench for axi_data_downsizer
module tb_axi_data_downsizer;

  logic        aclk;
  logic        areset;
  logic [66:0] prev_stage_data_i;
  logic        prev_stage_valid_i;
  logic        prev_stage_ready_o;
  logic [42:0] next_stage_data_o;
  logic        next_stage_last_o;
  logic        next_stage_valid_o;
  logic        next_stage_ready_i;

  int checks = 0;
  int errors = 0;

  axi_data_downsizer dut (
    .aclk               (aclk),
    .areset             (areset),
    .prev_stage_data_i  (prev_stage_data_i),
    .prev_stage_valid_i (prev_stage_valid_i),
    .prev_stage_ready_o (prev_stage_ready_o),
    .next_stage_data_o  (next_stage_data_o),
    .next_stage_last_o  (next_stage_last_o),
    .next_stage_valid_o (next_stage_valid_o),
    .next_stage_ready_i (next_stage_ready_i)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] id, input logic [31:0] addr,
                          input logic [7:0] dat, input logic last, input logic srdy);
    chk({tag, "_valid"}, 64'(next_stage_valid_o), 64'd1);
    chk({tag, "_id"},    64'(next_stage_data_o[42:40]), 64'(id));
    chk({tag, "_addr"},  64'(next_stage_data_o[39:8]), 64'(addr));
    chk({tag, "_data"},  64'(next_stage_data_o[7:0]), 64'(dat));
    chk({tag, "_last"},  64'(next_stage_last_o), 64'(last));
    chk({tag, "_sready"}, 64'(prev_stage_ready_o), 64'(srdy));
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic put(input logic [2:0] id, input logic [31:0] addr, input logic [31:0] dat);
    prev_stage_valid_i = 1'b1;
    prev_stage_data_i  = {id, addr, dat};
  endtask

  logic [7:0]  bytes_a [4];
  logic [7:0]  bytes_b [4];
  logic [31:0] addrs   [4];

  initial begin
    areset             = 1'b1;
    prev_stage_valid_i = 1'b0;
    prev_stage_data_i  = '0;
    next_stage_ready_i = 1'b1;
    @(negedge aclk);
    #1;
    chk("rst_valid",  64'(next_stage_valid_o), 64'd0);
    chk("rst_last",   64'(next_stage_last_o), 64'd0);
    chk("rst_data",   64'(next_stage_data_o), 64'd0);
    chk("rst_sready", 64'(prev_stage_ready_o), 64'd0);
    next_cycle();
    areset = 1'b0;
    #1;
    chk("idle_sready", 64'(prev_stage_ready_o), 64'd1);

    // 1. single word
    next_cycle();
    put(3'd2, 32'h100, 32'h44332211);
    #1;
    chk("t1_sready_idle", 64'(prev_stage_ready_o), 64'd1);
    next_cycle();
    prev_stage_valid_i = 1'b0;
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_beat($sformatf("t1_b%0d", k), 3'd2, 32'h100 + k, bytes_a[k], k == 3, k == 3);
      next_cycle();
    end
    #1;
    chk("t1_idle_valid", 64'(next_stage_valid_o), 64'd0);

    // 2. back-to-back words
    next_cycle();
    put(3'd1, 32'h0, 32'hDDCCBBAA);
    next_cycle();
    put(3'd1, 32'h4, 32'h44332211);
    bytes_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bytes_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_beat($sformatf("t2_a%0d", k), 3'd1, 32'h0 + k, bytes_a[k], k == 3, k == 3);
      next_cycle();
    end
    prev_stage_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_beat($sformatf("t2_b%0d", k), 3'd1, 32'h4 + k, bytes_b[k], k == 3, k == 3);
      next_cycle();
    end
    #1;
    chk("t2_idle_valid", 64'(next_stage_valid_o), 64'd0);

    // 3. downstream stall on beat 1
    next_cycle();
    put(3'd5, 32'h100, 32'h44332211);
    next_cycle();
    prev_stage_valid_i = 1'b0;
    #1;
    chk_beat("t3_b0", 3'd5, 32'h100, 8'h11, 1'b0, 1'b0);
    next_cycle();
    next_stage_ready_i = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      chk_beat($sformatf("t3_hold%0d", s), 3'd5, 32'h101, 8'h22, 1'b0, 1'b0);
      next_cycle();
    end
    next_stage_ready_i = 1'b1;
    #1;
    chk_beat("t3_b1", 3'd5, 32'h101, 8'h22, 1'b0, 1'b0);
    next_cycle();
    #1;
    chk_beat("t3_b2", 3'd5, 32'h102, 8'h33, 1'b0, 1'b0);
    next_cycle();
    #1;
    chk_beat("t3_b3", 3'd5, 32'h103, 8'h44, 1'b1, 1'b1);
    next_cycle();

    // 4. address wrap
    put(3'd7, 32'hFFFFFFFE, 32'h0D0C0B0A);
    next_cycle();
    prev_stage_valid_i = 1'b0;
    bytes_a = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    addrs   = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_beat($sformatf("t4_b%0d", k), 3'd7, addrs[k], bytes_a[k], k == 3, k == 3);
      next_cycle();
    end

    // 5. reset mid-word
    put(3'd3, 32'h200, 32'h88776655);
    next_cycle();
    prev_stage_valid_i = 1'b0;
    #1;
    chk_beat("t5_b0", 3'd3, 32'h200, 8'h55, 1'b0, 1'b0);
    next_cycle();
    areset = 1'b1;
    #1;
    chk("t5_rst_valid",  64'(next_stage_valid_o), 64'd0);
    chk("t5_rst_sready", 64'(prev_stage_ready_o), 64'd0);
    chk("t5_rst_data",   64'(next_stage_data_o), 64'd0);
    next_cycle();
    areset = 1'b0;
    #1;
    chk("t5_post_valid", 64'(next_stage_valid_o), 64'd0);
    next_cycle();
    #1;
    chk("t5_post_valid2", 64'(next_stage_valid_o), 64'd0);
    put(3'd4, 32'h300, 32'hCCBBAA99);
    next_cycle();
    prev_stage_valid_i = 1'b0;
    bytes_a = '{8'h99, 8'hAA, 8'hBB, 8'hCC};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_beat($sformatf("t5_n%0d", k), 3'd4, 32'h300 + k, bytes_a[k], k == 3, k == 3);
      next_cycle();
    end

    // 6. X data with valid low
    prev_stage_valid_i = 1'b0;
    prev_stage_data_i  = 'x;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t6_valid%0d", c), 64'(next_stage_valid_o), 64'd0);
      chk($sformatf("t6_xdata%0d", c), 64'($isunknown(next_stage_data_o)), 64'd0);
      chk($sformatf("t6_xctl%0d", c),
          64'($isunknown({next_stage_last_o, next_stage_valid_o, prev_stage_ready_o})), 64'd0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
